// File: rtl/mmio_word_fifo_if.sv
// rtl/mmio_word_fifo_if.sv - push/pop/status bundle for mmio_word_fifo (stats ports under MMIO_FIFO_STATS_EN)
interface mmio_word_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic [WIDTH-1:0] pop_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;
`ifdef MMIO_FIFO_STATS_EN
  logic [15:0]      ovf_cnt;
  logic [15:0]      udf_cnt;
`endif

  modport master (
    output push, push_data, pop, clr_err,
`ifdef MMIO_FIFO_STATS_EN
    input  ovf_cnt, udf_cnt,
`endif
    input  pop_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, clr_err,
`ifdef MMIO_FIFO_STATS_EN
    output ovf_cnt, udf_cnt,
`endif
    output pop_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/mmio_word_fifo.sv
// rtl/mmio_word_fifo.sv - first-word fall-through MMIO word FIFO with sticky errors (stats under MMIO_FIFO_STATS_EN)
module mmio_word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmio_word_fifo_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
`ifdef MMIO_FIFO_STATS_EN
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
  logic [15:0]      udf_cnt_q, udf_cnt_d;
`endif

  logic is_empty;
  logic is_full;
  logic acc_push;
  logic acc_pop;
  logic ovf_ev;
  logic udf_ev;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  // Stale words remain in storage after a pop, so the head is masked when empty.
  assign bus.pop_data  = is_empty ? '0 : mem_q[rd_ptr_q];
`ifdef MMIO_FIFO_STATS_EN
  assign bus.ovf_cnt   = ovf_cnt_q;
  assign bus.udf_cnt   = udf_cnt_q;
`endif

  // Next-state: accept/reject decisions, storage write, pointer/count update, error flags.
  always_comb begin
    acc_push = bus.push && (!is_full || bus.pop);
    acc_pop  = bus.pop && !is_empty;
    ovf_ev   = bus.push && is_full && !bus.pop;
    udf_ev   = bus.pop && is_empty;

    mem_d = mem_q;
    if (acc_push) mem_d[wr_ptr_q] = bus.push_data;

    wr_ptr_d = wr_ptr_q + AW'(acc_push);
    rd_ptr_d = rd_ptr_q + AW'(acc_pop);
    count_d  = count_q + CW'(acc_push) - CW'(acc_pop);

    // An error event in the clear cycle wins over the clear.
    overflow_d  = (overflow_q  && !bus.clr_err) || ovf_ev;
    underflow_d = (underflow_q && !bus.clr_err) || udf_ev;

`ifdef MMIO_FIFO_STATS_EN
    ovf_cnt_d = bus.clr_err ? 16'h0000 : ovf_cnt_q;
    if (ovf_ev && ovf_cnt_d != 16'hFFFF) ovf_cnt_d = ovf_cnt_d + 16'h0001;
    udf_cnt_d = bus.clr_err ? 16'h0000 : udf_cnt_q;
    if (udf_ev && udf_cnt_d != 16'hFFFF) udf_cnt_d = udf_cnt_d + 16'h0001;
`endif
  end

  // State registers; reset discards all contents including storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef MMIO_FIFO_STATS_EN
      ovf_cnt_q   <= 16'h0000;
      udf_cnt_q   <= 16'h0000;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef MMIO_FIFO_STATS_EN
      ovf_cnt_q   <= ovf_cnt_d;
      udf_cnt_q   <= udf_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mmio_word_fifo.sv
// tb/tb_mmio_word_fifo.sv - self-checking bench for mmio_word_fifo (stats checks under MMIO_FIFO_STATS_EN)
module tb_mmio_word_fifo;
  localparam int W = 64;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_word_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  mmio_word_fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb [$];

  typedef struct {
    logic         push;
    logic [W-1:0] data;
    logic         pop;
    logic         clr;
    int           exp_count;
    logic         exp_ovf;
    logic         exp_udf;
    logic [W-1:0] exp_head;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic p, input logic [W-1:0] d, input logic po, input logic c,
                              input int cnt, input logic ov, input logic ud, input logic [W-1:0] hd);
    vec_t v;
    v.push = p; v.data = d; v.pop = po; v.clr = c;
    v.exp_count = cnt; v.exp_ovf = ov; v.exp_udf = ud; v.exp_head = hd;
    vecs.push_back(v);
  endfunction

  // One clock of stimulus; the scoreboard checks the head word whenever a pop is accepted.
  task automatic step(input logic p, input logic [W-1:0] d, input logic po, input logic c);
    int old_size;
    logic [W-1:0] exp_pop;
    @(negedge clk);
    bus.push = p; bus.push_data = d; bus.pop = po; bus.clr_err = c;
    #1;
    old_size = sb.size();
    if (po && old_size > 0) begin
      exp_pop = sb.pop_front();
      chk("sb_pop_data", bus.pop_data, exp_pop);
    end
    if (p && (old_size < D || po)) sb.push_back(d);
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0; bus.clr_err = 1'b0;

    // order
    add(1, 64'h11, 0, 0, 1, 0, 0, 64'h11);
    add(1, 64'h22, 0, 0, 2, 0, 0, 64'h11);
    add(1, 64'h33, 0, 0, 3, 0, 0, 64'h11);
    add(0, 0, 1, 0, 2, 0, 0, 64'h22);
    add(0, 0, 1, 0, 1, 0, 0, 64'h33);
    add(0, 0, 1, 0, 0, 0, 0, 64'h0);
    // full / overflow
    for (int i = 0; i < 8; i++) add(1, 64'hA0 + 64'(i), 0, 0, i + 1, 0, 0, 64'hA0);
    add(1, 64'hFF, 0, 0, 8, 1, 0, 64'hA0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 7 - i, 1, 0, (i < 7) ? 64'hA1 + 64'(i) : 64'h0);
    add(0, 0, 0, 1, 0, 0, 0, 64'h0);
    // full push+pop, pointers wrap
    for (int i = 0; i < 8; i++) add(1, 64'hB0 + 64'(i), 0, 0, i + 1, 0, 0, 64'hB0);
    add(1, 64'hC0, 1, 0, 8, 0, 0, 64'hB1);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 0, 7 - i, 0, 0, (i < 6) ? 64'hB2 + 64'(i) : ((i == 6) ? 64'hC0 : 64'h0));
    // empty push+pop, clear, clear racing an error
    add(1, 64'h5, 1, 0, 1, 0, 1, 64'h5);
    add(0, 0, 0, 1, 1, 0, 0, 64'h5);
    add(0, 0, 1, 0, 0, 0, 0, 64'h0);
    add(0, 0, 1, 1, 0, 0, 1, 64'h0);
    add(0, 0, 0, 1, 0, 0, 0, 64'h0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_pop_data", bus.pop_data, 64'h0);
    chk("rst_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].data, vecs[i].pop, vecs[i].clr);
      chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_count));
      chk($sformatf("v%0d_empty", i), 64'(bus.empty), 64'(vecs[i].exp_count == 0));
      chk($sformatf("v%0d_full", i), 64'(bus.full), 64'(vecs[i].exp_count == D));
      chk($sformatf("v%0d_overflow", i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_underflow", i), 64'(bus.underflow), 64'(vecs[i].exp_udf));
      chk($sformatf("v%0d_pop_data", i), bus.pop_data, vecs[i].exp_head);
    end

    // reset mid-operation with a flag set and words stored
    step(0, 0, 1, 0);
    step(1, 64'h77, 0, 0);
    step(1, 64'h88, 0, 0);
    chk("pre_rst_count", 64'(bus.count), 64'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_empty", 64'(bus.empty), 64'd1);
    chk("mid_rst_full", 64'(bus.full), 64'd0);
    chk("mid_rst_pop_data", bus.pop_data, 64'h0);
    chk("mid_rst_flags", {62'd0, bus.overflow, bus.underflow}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, 64'h99, 0, 0);
    chk("post_rst_count", 64'(bus.count), 64'd1);
    chk("post_rst_head", bus.pop_data, 64'h99);
    step(0, 0, 1, 0);
    chk("post_rst_empty", 64'(bus.empty), 64'd1);

`ifdef MMIO_FIFO_STATS_EN
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    chk("udf_cnt_3", 64'(bus.udf_cnt), 64'd3);
    for (int i = 0; i < 8; i++) step(1, 64'hD0 + 64'(i), 0, 0);
    step(1, 64'hEE, 0, 0);
    step(1, 64'hEF, 0, 0);
    chk("ovf_cnt_2", 64'(bus.ovf_cnt), 64'd2);
    chk("udf_cnt_hold", 64'(bus.udf_cnt), 64'd3);
    step(0, 0, 0, 1);
    chk("ovf_cnt_clr", 64'(bus.ovf_cnt), 64'd0);
    chk("udf_cnt_clr", 64'(bus.udf_cnt), 64'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("udf_cnt_clr_event", 64'(bus.udf_cnt), 64'd1);
    @(negedge clk);
    bus.pop = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    bus.pop = 1'b0;
    chk("udf_cnt_sat", 64'(bus.udf_cnt), 64'hFFFF);
    chk("ovf_cnt_idle", 64'(bus.ovf_cnt), 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
